// File: rtl/bcd_decoder_seq_pkg.sv
// bcd_pkg: shared types, widths and helpers for the sequential BCD decoder
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} bcd_seq_state_e;
  function automatic int bcd_bin_width(input int n);
    return 3 * n + (n + 2) / 3;
  endfunction
endpackage

// File: rtl/bcd_decoder_seq_step.sv
// bcd_dabble_step: one reverse double-dabble iteration on {bcd, bin}
//   d  in   work value before the iteration
//   q  out  work value after shift right and per-digit minus-3 correction
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int N = 3,
  localparam int B = bcd_bin_width(N),
  localparam int W = BCD_DIGIT_W * N + B
)(
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s;
  assign s = d >> 1;
  assign q[B-1:0] = s[B-1:0];
  for (genvar i = 0; i < N; i++) begin : g_dig
    assign q[B+BCD_DIGIT_W*i +: BCD_DIGIT_W] = s[B+BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd7 ?
      s[B+BCD_DIGIT_W*i +: BCD_DIGIT_W] - 4'd3 : s[B+BCD_DIGIT_W*i +: BCD_DIGIT_W];
  end
endmodule

// File: rtl/bcd_decoder_seq.sv
// bcd_decoder_seq: handshaked multi-cycle BCD-to-binary converter, S dabble iterations per clock
//   i_clk, i_aresetn       clock, async active-low reset
//   i_bcd, i_valid, o_ready  input handshake (packed BCD, digit 0 in [3:0])
//   o_bin, o_valid, i_ready  output handshake (binary result held until i_ready)
//   o_err                  only with BCD_DECODER_SEQ_CHECK_EN: accepted input had a digit > 9
module bcd_decoder_seq
  import bcd_pkg::*;
#(
  parameter int N = 3,
  parameter int S = 1,
  localparam int B = bcd_bin_width(N)
)(
  input  logic                     i_clk,
  input  logic                     i_aresetn,
  input  logic [BCD_DIGIT_W*N-1:0] i_bcd,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [B-1:0]             o_bin,
  output logic                     o_valid,
  input  logic                     i_ready
`ifdef BCD_DECODER_SEQ_CHECK_EN
  ,output logic                    o_err
`endif
);
  localparam int W = BCD_DIGIT_W * N + B;
  localparam int CW = $clog2(B + 1);
  localparam logic [CW-1:0] BL = CW'(B);
  localparam logic [CW-1:0] SL = CW'(S);
  bcd_seq_state_e state, state_n;
  logic [W-1:0] work, nxt;
  logic [W-1:0] stage [S+1];
  logic [CW-1:0] cnt, rem, take;
  logic accept, fin;
  assign stage[0] = work;
  for (genvar k = 0; k < S; k++) begin : g_step
    bcd_dabble_step #(.N(N)) u_step (.d(stage[k]), .q(stage[k+1]));
  end
  // On the final cycle only the remaining iterations are taken; later stages are bypassed.
  always_comb begin
    rem = BL - cnt;
    take = rem > SL ? SL : rem;
    nxt = stage[0];
    for (int k = 1; k <= S; k++) if (take == CW'(k)) nxt = stage[k];
  end
  always_comb begin
    o_ready = state == IDLE || (state == DONE && i_ready);
    accept = i_valid && o_ready;
    fin = state == BUSY && cnt + take == BL;
    state_n = accept ? BUSY : fin ? DONE : (state == DONE && i_ready) ? IDLE : state;
  end
  assign o_valid = state == DONE;
  always_ff @(posedge i_clk or negedge i_aresetn)
    if (!i_aresetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge i_clk or negedge i_aresetn)
    if (!i_aresetn) begin
      work <= '0;
      cnt <= '0;
      o_bin <= '0;
    end else if (accept) begin
      work <= {i_bcd, {B{1'b0}}};
      cnt <= '0;
    end else if (state == BUSY) begin
      work <= nxt;
      cnt <= cnt + take;
      if (fin) o_bin <= nxt[B-1:0];
    end
`ifdef BCD_DECODER_SEQ_CHECK_EN
  logic bad, err_pend;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < N; i++) bad |= i_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd9;
  end
  always_ff @(posedge i_clk or negedge i_aresetn)
    if (!i_aresetn) begin
      err_pend <= 1'b0;
      o_err <= 1'b0;
    end else if (accept) begin
      err_pend <= bad;
      o_err <= 1'b0;
    end else if (fin) o_err <= err_pend;
`endif
endmodule

// File: tb/tb_bcd_decoder_seq.sv
// tb_bcd_decoder_seq: random and directed checks of bcd_decoder_seq against a decimal reference model
module tb_bcd_decoder_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic [11:0] bcd;
  logic vin, rin;
  logic [9:0] bin3 [4];
  logic v3 [4];
  logic rdy3 [4];
  logic [15:0] b_bcd;
  logic b_vin, b_rin, b_v, b_rdy;
  logic [13:0] b_bin;
`ifdef BCD_DECODER_SEQ_CHECK_EN
  logic err3 [4];
  logic b_err;
`endif
  int checks = 0;
  int errors = 0;
  int sl [4] = '{1, 2, 5, 10};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int SG = g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10;
    bcd_decoder_seq #(.N(3), .S(SG)) u_dut (
      .i_clk(clk), .i_aresetn(rst_n), .i_bcd(bcd), .i_valid(vin), .o_ready(rdy3[g]),
      .o_bin(bin3[g]), .o_valid(v3[g]), .i_ready(rin)
`ifdef BCD_DECODER_SEQ_CHECK_EN
      , .o_err(err3[g])
`endif
    );
  end
  bcd_decoder_seq #(.N(4), .S(5)) u_dut4 (
    .i_clk(clk), .i_aresetn(rst_n), .i_bcd(b_bcd), .i_valid(b_vin), .o_ready(b_rdy),
    .o_bin(b_bin), .o_valid(b_v), .i_ready(b_rin)
`ifdef BCD_DECODER_SEQ_CHECK_EN
    , .o_err(b_err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic int exp_lat(input int bw, input int s);
    return (bw + s - 1) / s;
  endfunction
  task automatic start(input logic [11:0] val);
    @(negedge clk);
    rin = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) chk($sformatf("ready s=%0d", sl[g]), rdy3[g], 1);
    bcd = val;
    vin = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0;
    rin = 1'b0;
    bcd = 12'($urandom);
  endtask
  task automatic collect(input int exp, input bit chk_bin);
    int lat [4] = '{0, 0, 0, 0};
    bit all;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      all = 1'b1;
      for (int g = 0; g < 4; g++) begin
        if (lat[g] == 0 && v3[g]) lat[g] = c;
        if (lat[g] == 0) all = 1'b0;
      end
      if (all) break;
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("latency s=%0d", sl[g]), lat[g], exp_lat(10, sl[g]));
      if (chk_bin) chk($sformatf("bin s=%0d val=%0d", sl[g], exp), bin3[g], exp);
    end
  endtask
  task automatic retire();
    @(negedge clk);
    rin = 1'b1;
    @(posedge clk);
    #1;
    rin = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("valid drop s=%0d", sl[g]), v3[g], 0);
      chk($sformatf("idle ready s=%0d", sl[g]), rdy3[g], 1);
    end
  endtask
  task automatic b_conv(input int v);
    int lat = 0;
    @(negedge clk);
    b_rin = 1'b1;
    #1;
    chk("n4 ready", b_rdy, 1);
    b_bcd = to_bcd(v);
    b_vin = 1'b1;
    @(posedge clk);
    #1;
    b_vin = 1'b0;
    b_rin = 1'b0;
    b_bcd = 16'($urandom);
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (b_v) lat = c;
    end
    chk("n4 latency", lat, exp_lat(14, 5));
    chk($sformatf("n4 bin val=%0d", v), b_bin, v);
  endtask
  initial begin
    rst_n = 1'b0;
    vin = 1'b0;
    rin = 1'b0;
    bcd = '0;
    b_vin = 1'b0;
    b_rin = 1'b0;
    b_bcd = '0;
    #12;
    for (int g = 0; g < 4; g++) begin
      chk("reset valid", v3[g], 0);
      chk("reset bin", bin3[g], 0);
      chk("reset ready", rdy3[g], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start(12'h999);
    collect(999, 1);
    retire();
    start(12'h000);
    collect(0, 1);
    retire();
    start(12'h001);
    collect(1, 1);
    start(12'h512);
    collect(512, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
        chk("hold valid", v3[g], 1);
        chk("hold bin", bin3[g], 512);
      end
    end
    start(12'h047);
    collect(47, 1);
    retire();
    start(12'h123);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("async valid drop", v3[g], 0);
      chk("async bin clear", bin3[g], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("post reset valid", v3[g], 0);
      chk("post reset ready", rdy3[g], 1);
    end
    start(12'h250);
    collect(250, 1);
    retire();
`ifdef BCD_DECODER_SEQ_CHECK_EN
    start(12'h9A9);
    collect(0, 0);
    for (int g = 0; g < 4; g++) chk("err set", err3[g], 1);
    start(12'h123);
    collect(123, 1);
    for (int g = 0; g < 4; g++) chk("err clear", err3[g], 0);
    retire();
`endif
    start(12'hFAB);
    collect(0, 0);
    retire();
    for (int v = 0; v < 1000; v++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      start(12'(to_bcd(v)));
      collect(v, 1);
      if ($urandom_range(3) == 0) retire();
    end
    b_conv(9999);
    b_conv(0);
    for (int i = 0; i < 20; i++) b_conv(int'($urandom_range(9999)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
